// File: rtl/jk_excitation_sequencer.sv
// Derives J/K drive for a target word from the JK excitation table, applies it to an
// internal JK flop bank and confirms the bank landed on the target.
module jk_excitation_sequencer #(
    parameter int WIDTH     = 4,
    parameter int DC_POLICY = 0,
    parameter int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             fault_inj,
    input  logic             err_clr,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    toggle_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic DC = (DC_POLICY != 0);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_reg;
    logic [WIDTH-1:0] j_ex, k_ex, q_nxt;
    logic             accept, match, err_reg;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // Excitation table: a flop at 0 only cares about J, a flop at 1 only about K.
    always_comb begin
        j_ex = '0;
        k_ex = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) begin
                j_ex[i] = DC;
                k_ex[i] = ~tgt_data[i];
            end else begin
                j_ex[i] = tgt_data[i];
                k_ex[i] = DC;
            end
        end
    end

    always_comb begin
        q_nxt = q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j_out[i], k_out[i]})
                2'b00:   q_nxt[i] = q[i];
                2'b01:   q_nxt[i] = 1'b0;
                2'b10:   q_nxt[i] = 1'b1;
                default: q_nxt[i] = ~q[i];
            endcase
        end
        if (fault_inj) q_nxt[0] = ~q_nxt[0];
    end

    assign match = (q == tgt_reg);
    assign qbar  = ~q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tgt_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        err       = err_reg;
        case (state)
            IDLE: begin
                tgt_ready = 1'b1;
                accept    = tgt_valid;
                if (tgt_valid) state_nxt = APPLY;
            end
            APPLY: begin
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                done      = match;
                err       = err_reg | ~match;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            tgt_reg    <= '0;
            j_out      <= '0;
            k_out      <= '0;
            toggle_cnt <= '0;
        end else begin
            if (accept) begin
                tgt_reg    <= tgt_data;
                toggle_cnt <= popcount(q ^ tgt_data);
                j_out      <= j_ex;
                k_out      <= k_ex;
            end
            if (state == APPLY) q <= q_nxt;
            if (state == CHECK) begin
                j_out <= '0;
                k_out <= '0;
            end
        end
    end

    // A fresh mismatch takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_reg <= 1'b0;
        else if (state == CHECK && !match)   err_reg <= 1'b1;
        else if (err_clr)                    err_reg <= 1'b0;
    end

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Scoreboard bench for jk_excitation_sequencer, WIDTH=4, both don't-care policies side by side.
module tb_jk_excitation_sequencer;

    logic       clk, rst, tgt_valid, fault_inj, err_clr;
    logic [3:0] tgt_data;
    logic [3:0] j0, k0, q0, qb0, j1, k1, q1, qb1;
    logic       rdy0, busy0, done0, err0, rdy1, busy1, done1, err1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] j0, k0, j1, k1;
        logic [3:0] q_exp;
        logic [2:0] cnt;
        logic       mism;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] qm;
    logic       errm;

    jk_excitation_sequencer #(.WIDTH(4), .DC_POLICY(0)) u_dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy0), .tgt_data(tgt_data),
        .fault_inj(fault_inj), .err_clr(err_clr), .j_out(j0), .k_out(k0), .q(q0), .qbar(qb0),
        .busy(busy0), .done(done0), .err(err0), .toggle_cnt(cnt0));

    jk_excitation_sequencer #(.WIDTH(4), .DC_POLICY(1)) u_dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy1), .tgt_data(tgt_data),
        .fault_inj(fault_inj), .err_clr(err_clr), .j_out(j1), .k_out(k1), .q(q1), .qbar(qb1),
        .busy(busy1), .done(done1), .err(err1), .toggle_cnt(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK excitation table, written out as the four transitions.
    function automatic logic [3:0] mj(input logic [3:0] q, input logic [3:0] t, input logic dc);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            case ({q[i], t[i]})
                2'b00: r[i] = 1'b0;
                2'b01: r[i] = 1'b1;
                2'b10: r[i] = dc;
                default: r[i] = dc;
            endcase
        return r;
    endfunction

    function automatic logic [3:0] mk(input logic [3:0] q, input logic [3:0] t, input logic dc);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            case ({q[i], t[i]})
                2'b00: r[i] = dc;
                2'b01: r[i] = dc;
                2'b10: r[i] = 1'b1;
                default: r[i] = 1'b0;
            endcase
        return r;
    endfunction

    function automatic exp_t make_exp(input logic [3:0] q, input logic [3:0] t, input logic f);
        exp_t e;
        int   n;
        e.tgt = t;
        e.j0  = mj(q, t, 1'b0);
        e.k0  = mk(q, t, 1'b0);
        e.j1  = mj(q, t, 1'b1);
        e.k1  = mk(q, t, 1'b1);
        e.q_exp = (e.j0 & ~q) | (~e.k0 & q);
        if (f) e.q_exp[0] = ~e.q_exp[0];
        n = 0;
        for (int i = 0; i < 4; i++) if (q[i] != t[i]) n++;
        e.cnt  = 3'(n);
        e.mism = (e.q_exp != t);
        return e;
    endfunction

    task automatic txn(input logic [3:0] t, input logic f, input logic clr);
        exp_t e;
        int   n;
        sb.push_back(make_exp(qm, t, f));
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = t;
        n = 0;
        while (!rdy0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL txn_ready_timeout got ready=%b exp 1", rdy0);
        end
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        fault_inj = f;
        e = sb.pop_front();
        checks++;
        if ({j0, k0} !== {e.j0, e.k0}) begin
            errors++;
            $display("FAIL jk_dc0 tgt=%b got j=%b k=%b exp j=%b k=%b", t, j0, k0, e.j0, e.k0);
        end
        checks++;
        if ({j1, k1} !== {e.j1, e.k1}) begin
            errors++;
            $display("FAIL jk_dc1 tgt=%b got j=%b k=%b exp j=%b k=%b", t, j1, k1, e.j1, e.k1);
        end
        checks++;
        if ({cnt0, cnt1} !== {e.cnt, e.cnt}) begin
            errors++;
            $display("FAIL toggle_cnt got %0d/%0d exp %0d", cnt0, cnt1, e.cnt);
        end
        checks++;
        if ({busy0, rdy0, done0, busy1, rdy1} !== 5'b10010) begin
            errors++;
            $display("FAIL apply_flags got busy=%b ready=%b done=%b exp busy=1 ready=0 done=0", busy0, rdy0, done0);
        end
        @(posedge clk); #1;
        fault_inj = 1'b0;
        err_clr   = clr;
        checks++;
        if ({q0, q1, qb0, qb1} !== {e.q_exp, e.q_exp, ~e.q_exp, ~e.q_exp}) begin
            errors++;
            $display("FAIL check_q got q=%b/%b qbar=%b/%b exp q=%b", q0, q1, qb0, qb1, e.q_exp);
        end
        checks++;
        if ({done0, done1, err0, err1, busy0} !== {!e.mism, !e.mism, errm | e.mism, errm | e.mism, 1'b1}) begin
            errors++;
            $display("FAIL check_flags got done=%b/%b err=%b/%b exp done=%b err=%b",
                     done0, done1, err0, err1, !e.mism, errm | e.mism);
        end
        if (e.mism) errm = 1'b1;
        else if (clr) errm = 1'b0;
        qm = e.q_exp;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checks++;
        if ({j0, k0, j1, k1, rdy0, done0, busy0, err0} !== {16'h0, 1'b1, 1'b0, 1'b0, errm}) begin
            errors++;
            $display("FAIL idle_return got j=%b k=%b ready=%b done=%b busy=%b err=%b exp err=%b",
                     j0, k0, rdy0, done0, busy0, err0, errm);
        end
    endtask

    task automatic test_reset();
        #23 rst = 1'b1;
        #1;
        checks++;
        if ({q0, qb0, q1, qb1} !== {4'h0, 4'hF, 4'h0, 4'hF}) begin
            errors++;
            $display("FAIL reset_q got q=%b qbar=%b exp q=0000 qbar=1111", q0, qb0);
        end
        checks++;
        if ({rdy0, busy0, done0, err0, j0, k0, cnt0, rdy1, j1, k1} !== {4'b1000, 8'h0, 3'd0, 1'b1, 8'h0}) begin
            errors++;
            $display("FAIL reset_flags got ready=%b busy=%b done=%b err=%b j=%b k=%b cnt=%0d",
                     rdy0, busy0, done0, err0, j0, k0, cnt0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({q0, qb0, rdy0} !== {4'h0, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL reset_held got q=%b qbar=%b ready=%b", q0, qb0, rdy0);
        end
        @(negedge clk);
        rst  = 1'b0;
        qm   = 4'h0;
        errm = 1'b0;
    endtask

    task automatic test_basic();
        txn(4'b1010, 1'b0, 1'b0);
    endtask

    task automatic test_policies();
        txn(4'b0110, 1'b0, 1'b0);
    endtask

    task automatic test_equal_target();
        txn(4'b0110, 1'b0, 1'b0);
    endtask

    task automatic test_fault();
        txn(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        fault_inj = 1'b1;
        repeat (2) @(negedge clk);
        fault_inj = 1'b0;
        checks++;
        if (q0 !== 4'b0000) begin
            errors++;
            $display("FAIL fault_outside_apply got q=%b exp 0000", q0);
        end
        txn(4'b1111, 1'b1, 1'b0);
        txn(4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        errm    = 1'b0;
        checks++;
        if ({err0, err1} !== 2'b00) begin
            errors++;
            $display("FAIL err_clr got err=%b/%b exp 0", err0, err1);
        end
        txn(4'b1100, 1'b1, 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        errm    = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ph = 0;
        int   accepts = 0;
        @(negedge clk);
        tgt_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (rdy0 !== (ph == 0)) begin
                errors++;
                $display("FAIL b2b_ready cycle=%0d got %b exp %b", c, rdy0, (ph == 0));
            end
            if (ph == 2) begin
                e = sb.pop_front();
                checks++;
                if ({q0, q1, done0, done1} !== {e.q_exp, e.q_exp, 2'b11}) begin
                    errors++;
                    $display("FAIL b2b_q cycle=%0d got q=%b/%b done=%b exp q=%b done=1",
                             c, q0, q1, done0, e.q_exp);
                end
            end
            if (ph == 0) begin
                tgt_data = 4'($urandom_range(0, 15));
                e = make_exp(qm, tgt_data, 1'b0);
                sb.push_back(e);
                qm = e.q_exp;
                accepts++;
                ph = 1;
            end else begin
                tgt_data = 4'($urandom_range(0, 15));
                ph = (ph == 1) ? 2 : 0;
            end
        end
        tgt_valid = 1'b0;
        checks++;
        if (accepts != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got accepts=%0d pending=%0d exp 4/0", accepts, sb.size());
        end
    endtask

    task automatic test_reset_in_apply();
        int dn = 0;
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = ~qm;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q0, qb0, busy0, rdy0, j0, k0, cnt0} !== {4'h0, 4'hF, 2'b01, 8'h0, 3'd0}) begin
            errors++;
            $display("FAIL rst_apply got q=%b qbar=%b busy=%b ready=%b j=%b k=%b cnt=%0d",
                     q0, qb0, busy0, rdy0, j0, k0, cnt0);
        end
        @(negedge clk);
        rst = 1'b0;
        qm  = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done0 || busy0) dn++;
        end
        checks++;
        if ({q0, q1} !== 8'h00 || dn != 0) begin
            errors++;
            $display("FAIL rst_drop got q=%b activity=%0d exp q=0000 activity=0", q0, dn);
        end
    endtask

    initial begin
        rst       = 1'b0;
        tgt_valid = 1'b0;
        tgt_data  = 4'h0;
        fault_inj = 1'b0;
        err_clr   = 1'b0;
        qm        = 4'h0;
        errm      = 1'b0;
        test_reset();
        test_basic();
        test_policies();
        test_equal_target();
        test_fault();
        test_back_to_back();
        test_reset_in_apply();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
